mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single 16-bit memory port between two masters: m0 = cpu (fetch + ld/st), m1 = aux
//  master (program loader / debug). One command per cycle, zero-latency issue to memory.
//  Fixed-latency reads; responses are tagged and routed back to the issuing master.
//  Sits between cpu and the memory, replacing the direct cpu->mem connection.
// PARAMETERS
//  RD_LAT    1  memory read latency in cycles (i_mem_rddata valid RD_LAT cycles after o_mem_rd); >=1
//  MAX_HOLD  4  max consecutive grants to one master while the other is requesting; >=1
// PORTS
//  clk           in   1   clock
//  reset         in   1   synchronous, active-high reset
//  m0_req        in   1   m0 command valid; held with addr/we/wrdata until m0_gnt
//  m0_we         in   1   1 = write, 0 = read
//  m0_addr       in   16  byte address
//  m0_wrdata     in   16  write data
//  m0_gnt        out  1   command issued to memory this cycle
//  m0_rvalid     out  1   read data for m0 on mX_rddata this cycle
//  m1_req/m1_we/m1_addr/m1_wrdata/m1_gnt/m1_rvalid  as m0, for m1
//  mX_rddata     out  16  = i_mem_rddata (shared, qualified by mN_rvalid)
//  o_mem_addr    out  16  memory address
//  o_mem_rd      out  1   memory read strobe
//  o_mem_wr      out  1   memory write strobe
//  o_mem_wrdata  out  16  memory write data
//  i_mem_rddata  in   16  memory read data
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0 (m0 preferred), hold_cnt=0, tag pipe cleared; all gnt/rvalid/o_mem_rd/
//   o_mem_wr = 0 in reset cycle and cycle after unless a req is present post-reset.
//  FSM {IDLE, OWN0, OWN1}: owner = master granted last cycle.
//   IDLE: no req -> stay; one req -> grant it, go OWNn; both -> grant rr_ptr master.
//   OWNn: reqn only -> grant n, hold_cnt++ (saturate); other only -> grant other, go OWNother, hold_cnt=1;
//    both -> grant n while hold_cnt<MAX_HOLD, else grant other, go OWNother, hold_cnt=1;
//    none -> go IDLE, hold_cnt=0.
//   rr_ptr <= ~granted id on every grant (loser preferred next IDLE contention).
//  Issue: gnt combinational same cycle as req (single-cycle grant decision from registered state);
//   o_mem_* driven combinationally from the granted master; o_mem_rd = gnt & ~we, o_mem_wr = gnt & we.
//   No grant -> o_mem_rd=o_mem_wr=0, o_mem_addr/wrdata = m0 values (don't-care).
//  Read return: RD_LAT-stage pipe of {valid,id}; stage0 loaded with {o_mem_rd, granted id};
//   mN_rvalid = pipe[RD_LAT-1].valid & id==N. Writes produce no rvalid.
//  Throughput: one command/cycle; back-to-back reads from alternating masters return in issue order.
//  Exactly one of m0_gnt/m1_gnt at most per cycle; never gnt without req.
//  Reset mid-operation: in-flight reads dropped (no rvalid after reset), FSM to IDLE.
//  Master dropping req before gnt: legal, no command issued; hold_cnt unaffected that cycle except
//   per FSM rules above.
// STRUCTURE
//  Package mem_arb_pkg: typedef enum logic[1:0] arb_state_t {IDLE,OWN0,OWN1}; localparams M0_ID=1'b0,
//   M1_ID=1'b1; typedef struct packed {logic valid; logic id;} rd_tag_t.
//  Sub-module rd_tag_pipe #(RD_LAT): clk/reset, in rd_tag_t, out rd_tag_t; plain shift register.
//  FSM, rr_ptr, hold_cnt ($clog2(MAX_HOLD+1) bits), issue mux in this module.
// TESTING
//  1. m0 read addr 0x0010 alone, mem returns 0xBEEF, RD_LAT=1 -> m0_gnt same cycle, o_mem_rd=1,
//     m0_rvalid=1 with rddata 0xBEEF next cycle, m1_rvalid stays 0.
//  2. Both req reads continuously from IDLE after reset, MAX_HOLD=4 -> grants m0 x4, m1 x4, m0 x4...;
//     rvalid ids follow grant order delayed RD_LAT.
//  3. m1 write 0x1234 to 0x0200 while m0 idle -> o_mem_wr=1, o_mem_wrdata=0x1234, no rvalid on either.
//  4. m0 read issued, reset asserted next cycle (RD_LAT=2) -> no m0_rvalid ever, state IDLE, outputs 0.
//  5. m0 alone 6 reads then m1 req -> m1 granted first cycle it requests (hold limit only under contention).
//  6. RD_LAT=3, interleaved m0 read / m1 read / m0 write -> exactly two rvalids, ids 0 then 1, spaced 1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and ids for the two-master memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } arb_state_t;

  localparam logic M0_ID = 1'b0;
  localparam logic M1_ID = 1'b1;

  // Read-return tag: travels alongside an outstanding read to route the data back.
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-length shift register carrying read tags until the memory data returns.
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t pipe_q [RD_LAT];

  // Shift tags one stage per cycle; reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_in;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_out = pipe_q[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single 16-bit memory port: zero-latency issue, bounded
// ownership under contention, fixed-latency tagged read return.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wrdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wrdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [15:0] mX_rddata,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [15:0] o_mem_wrdata,
  input  logic [15:0] i_mem_rddata
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);
  localparam logic [HoldW-1:0] HoldOne = HoldW'(1);

  arb_state_t       state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [HoldW-1:0] hold_q, hold_d;

  logic    gnt_valid, gnt_id;
  logic    own_id, own_req, oth_req;
  logic    sel_id, sel_we;
  rd_tag_t tag_in, tag_out;

  assign own_id  = (state_q == OWN1);
  assign own_req = own_id ? m1_req : m0_req;
  assign oth_req = own_id ? m0_req : m1_req;

  // Grant decision and next state from registered ownership, hold count and rr pointer.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = M0_ID;
    state_d   = state_q;
    hold_d    = hold_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          gnt_valid = 1'b1;
          gnt_id    = rr_ptr_q;
        end else if (m0_req || m1_req) begin
          gnt_valid = 1'b1;
          gnt_id    = m1_req ? M1_ID : M0_ID;
        end
        if (gnt_valid) begin
          state_d = gnt_id ? OWN1 : OWN0;
          hold_d  = HoldOne;
        end
      end
      OWN0, OWN1: begin
        if (own_req && (!oth_req || hold_q < HoldMax)) begin
          // Keep ownership; the count only saturates when nobody else is waiting.
          gnt_valid = 1'b1;
          gnt_id    = own_id;
          hold_d    = (hold_q == HoldMax) ? hold_q : hold_q + HoldOne;
        end else if (oth_req) begin
          gnt_valid = 1'b1;
          gnt_id    = ~own_id;
          state_d   = own_id ? OWN0 : OWN1;
          hold_d    = HoldOne;
        end else begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
    if (gnt_valid) begin
      rr_ptr_d = ~gnt_id;
    end
    // No command may leave the block while reset is asserted.
    if (reset) begin
      gnt_valid = 1'b0;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= M0_ID;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
    end
  end

  // Issue mux: without a grant the port shows m0's fields with both strobes low.
  always_comb begin
    sel_id       = gnt_valid & gnt_id;
    sel_we       = sel_id ? m1_we : m0_we;
    o_mem_addr   = sel_id ? m1_addr : m0_addr;
    o_mem_wrdata = sel_id ? m1_wrdata : m0_wrdata;
    o_mem_rd     = gnt_valid & ~sel_we;
    o_mem_wr     = gnt_valid & sel_we;
    m0_gnt       = gnt_valid & (gnt_id == M0_ID);
    m1_gnt       = gnt_valid & (gnt_id == M1_ID);
  end

  assign tag_in = '{valid: o_mem_rd, id: sel_id};

  rd_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rd_tag_pipe (
    .clk    (clk),
    .reset  (reset),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  assign m0_rvalid = tag_out.valid & (tag_out.id == M0_ID);
  assign m1_rvalid = tag_out.valid & (tag_out.id == M1_ID);
  assign mX_rddata = i_mem_rddata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters (RD_LAT 1,2,3) share one stimulus stream.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m0_wrdata, m1_addr, m1_wrdata, mem_rddata;

  logic        g0_w [3];
  logic        g1_w [3];
  logic        v0_w [3];
  logic        v1_w [3];
  logic        rd_w [3];
  logic        wr_w [3];
  logic [15:0] addr_w [3];
  logic [15:0] wdat_w [3];
  logic [15:0] rdat_w [3];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mem_port_arbiter #(
      .RD_LAT  (k + 1),
      .MAX_HOLD(4)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .m0_req      (m0_req),
      .m0_we       (m0_we),
      .m0_addr     (m0_addr),
      .m0_wrdata   (m0_wrdata),
      .m0_gnt      (g0_w[k]),
      .m0_rvalid   (v0_w[k]),
      .m1_req      (m1_req),
      .m1_we       (m1_we),
      .m1_addr     (m1_addr),
      .m1_wrdata   (m1_wrdata),
      .m1_gnt      (g1_w[k]),
      .m1_rvalid   (v1_w[k]),
      .mX_rddata   (rdat_w[k]),
      .o_mem_addr  (addr_w[k]),
      .o_mem_rd    (rd_w[k]),
      .o_mem_wr    (wr_w[k]),
      .o_mem_wrdata(wdat_w[k]),
      .i_mem_rddata(mem_rddata)
    );
  end

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdat;
    logic        v0;
    logic        v1;
    logic [15:0] rdat;
  } out_t;

  typedef struct {
    logic        rst;
    logic        r0;
    logic        w0;
    logic [15:0] a0;
    logic        r1;
    logic        w1;
    logic [15:0] a1;
    out_t        exp;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic rst, r0, w0, input logic [15:0] a0,
                              input logic r1, w1, input logic [15:0] a1,
                              input logic g0, g1, rd, wr, input logic [15:0] addr, wdat,
                              input logic v0, v1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.r1 = r1; v.w1 = w1; v.a1 = a1;
    v.exp = '{g0: g0, g1: g1, rd: rd, wr: wr, addr: addr, wdat: wdat, v0: v0, v1: v1,
              rdat: 16'h0000};
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, r0, w0, input logic [15:0] a0,
                       input logic r1, w1, input logic [15:0] a1);
    reset = rst; m0_req = r0; m0_we = w0; m0_addr = a0;
    m1_req = r1; m1_we = w1; m1_addr = a1;
  endtask

  function automatic out_t sample(input int d);
    out_t o;
    o.g0 = g0_w[d]; o.g1 = g1_w[d]; o.rd = rd_w[d]; o.wr = wr_w[d];
    o.addr = addr_w[d]; o.wdat = wdat_w[d]; o.v0 = v0_w[d]; o.v1 = v1_w[d];
    o.rdat = rdat_w[d];
    return o;
  endfunction

  // One cycle: inputs already driven, sample mid-cycle, move past the next edge.
  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle();
    drive(1'b1, 1'b0, 1'b0, 16'h0020, 1'b0, 1'b0, 16'h0030);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int hist [24];
    out_t e;
    m0_wrdata  = 16'hA5A5;
    m1_wrdata  = 16'h1234;
    mem_rddata = 16'h0000;
    reset_cycle();
    reset_cycle();

    //               rst r0 w0 a0        r1 w1 a1         g0 g1 rd wr addr      wdat      v0 v1
    vecs[0]  = mk(1, 1, 0, 16'h0010, 0, 0, 16'h0200, 0, 0, 0, 0, 16'h0010, 16'hA5A5, 0, 0);
    vecs[1]  = mk(0, 0, 0, 16'h0010, 0, 0, 16'h0200, 0, 0, 0, 0, 16'h0010, 16'hA5A5, 0, 0);
    vecs[2]  = mk(0, 1, 0, 16'h0010, 0, 0, 16'h0200, 1, 0, 1, 0, 16'h0010, 16'hA5A5, 0, 0);
    vecs[3]  = mk(0, 0, 0, 16'h0010, 0, 0, 16'h0200, 0, 0, 0, 0, 16'h0010, 16'hA5A5, 1, 0);
    vecs[4]  = mk(0, 0, 0, 16'h0010, 1, 1, 16'h0200, 0, 1, 0, 1, 16'h0200, 16'h1234, 0, 0);
    vecs[5]  = mk(0, 0, 0, 16'h0010, 0, 0, 16'h0200, 0, 0, 0, 0, 16'h0010, 16'hA5A5, 0, 0);
    vecs[6]  = mk(0, 1, 0, 16'h000A, 1, 0, 16'h000B, 1, 0, 1, 0, 16'h000A, 16'hA5A5, 0, 0);
    vecs[7]  = mk(0, 0, 0, 16'h000A, 0, 0, 16'h000B, 0, 0, 0, 0, 16'h000A, 16'hA5A5, 1, 0);
    vecs[8]  = mk(0, 1, 0, 16'h000A, 1, 0, 16'h000B, 0, 1, 1, 0, 16'h000B, 16'h1234, 0, 0);
    vecs[9]  = mk(0, 0, 0, 16'h000A, 0, 0, 16'h000B, 0, 0, 0, 0, 16'h000A, 16'hA5A5, 0, 1);
    vecs[10] = mk(0, 0, 0, 16'h000A, 1, 0, 16'h000B, 0, 1, 1, 0, 16'h000B, 16'h1234, 0, 0);
    vecs[11] = mk(0, 1, 0, 16'h000A, 0, 0, 16'h000B, 1, 0, 1, 0, 16'h000A, 16'hA5A5, 0, 1);
    vecs[12] = mk(0, 1, 1, 16'h000C, 0, 0, 16'h000B, 1, 0, 0, 1, 16'h000C, 16'hA5A5, 1, 0);
    vecs[13] = mk(0, 0, 0, 16'h000C, 0, 0, 16'h000B, 0, 0, 0, 0, 16'h000C, 16'hA5A5, 0, 0);
    vecs[14] = mk(1, 1, 0, 16'h000A, 1, 0, 16'h000B, 0, 0, 0, 0, 16'h000A, 16'hA5A5, 0, 0);
    vecs[15] = mk(0, 0, 0, 16'h000A, 0, 0, 16'h000B, 0, 0, 0, 0, 16'h000A, 16'hA5A5, 0, 0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].r1, vecs[i].w1,
            vecs[i].a1);
      mem_rddata = 16'hBE00 + 16'(i);
      e = vecs[i].exp;
      e.rdat = 16'hBE00 + 16'(i);
      to_sample();
      chk($sformatf("vec%0d", i), 64'(sample(0)), 64'(e));
      next_cycle();
    end

    // Continuous contention: four grants each, alternating, rvalid ids follow issue order.
    reset_cycle();
    for (int k = 0; k < 24; k++) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0020, 1'b1, 1'b0, 16'h0030);
      mem_rddata = 16'h7000 + 16'(k);
      hist[k] = (k / 4) % 2;
      to_sample();
      for (int d = 0; d < 3; d++) begin
        e.g0 = (hist[k] == 0); e.g1 = (hist[k] == 1); e.rd = 1'b1; e.wr = 1'b0;
        e.addr = (hist[k] == 1) ? 16'h0030 : 16'h0020;
        e.wdat = (hist[k] == 1) ? 16'h1234 : 16'hA5A5;
        e.v0 = (k > d) ? (hist[k-d-1] == 0) : 1'b0;
        e.v1 = (k > d) ? (hist[k-d-1] == 1) : 1'b0;
        e.rdat = 16'h7000 + 16'(k);
        chk($sformatf("contend c%0d lat%0d", k, d + 1), 64'(sample(d)), 64'(e));
      end
      next_cycle();
    end

    // Reset one cycle after a read issue with RD_LAT=2: the read never returns.
    reset_cycle();
    drive(1'b0, 1'b1, 1'b0, 16'h0040, 1'b0, 1'b0, 16'h0030);
    to_sample();
    chk("rst_mid issue", {62'd0, g0_w[1], rd_w[1]}, 64'd3);
    next_cycle();
    for (int k = 1; k < 6; k++) begin
      drive(k == 1, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0, 16'h0030);
      to_sample();
      chk($sformatf("rst_mid quiet c%0d", k),
          {58'd0, g0_w[1], g1_w[1], rd_w[1], wr_w[1], v0_w[1], v1_w[1]}, 64'd0);
      next_cycle();
    end
    drive(1'b0, 1'b1, 1'b0, 16'h0040, 1'b1, 1'b0, 16'h0030);
    to_sample();
    chk("rst_mid rr back to m0", {62'd0, g0_w[1], g1_w[1]}, 64'd2);
    next_cycle();

    // Uncontended streak saturates the hold count; m1 still wins on its first request.
    reset_cycle();
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0050, (k == 6) || (k == 7), 1'b0, 16'h0060);
      to_sample();
      chk($sformatf("hold c%0d", k), {62'd0, g0_w[0], g1_w[0]},
          ((k == 6) || (k == 7)) ? 64'd1 : 64'd2);
      next_cycle();
    end

    // m0 read, m1 read, m0 write: two returns per latency, ids 0 then 1 one cycle apart.
    reset_cycle();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, (k == 0) || (k == 2), k == 2, 16'h0070, k == 1, 1'b0, 16'h0080);
      to_sample();
      chk($sformatf("mix grant c%0d", k), {60'd0, g0_w[2], g1_w[2], rd_w[2], wr_w[2]},
          (k == 0) ? 64'hA : (k == 1) ? 64'h6 : (k == 2) ? 64'h9 : 64'h0);
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("mix rvalid c%0d lat%0d", k, d + 1), {62'd0, v0_w[d], v1_w[d]},
            {62'd0, k == d + 1, k == d + 2});
      end
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
